rvb_shifter_arbiter: RTL and testbench
======================================

# rvb_shifter_arbiter

Shares one `rvb_shifter` instance between two independent requesters, for example two issue slots or two harts. Requests are accepted round-robin into a registered issue stage that drives the shifter's `din_*` handshake. An in-order tag FIFO records which port issued each operation. Shifter results are steered back to the owning requester's response port with full valid/ready backpressure. The block sits between the decode/issue logic and the shifter.

## Interface
- `XLEN`, 32: datapath width; 32 or 64.
- `DEPTH`, 4: maximum outstanding operations (issue register plus shifter); power of two, at least 2.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0_valid` / `req1_valid`  in  1  request offered on port 0/1.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid && ready.
- `req0_rs1`, `req0_rs2`, `req0_rs3` / `req1_*`  in  XLEN  operands.
- `req0_insn` / `req1_insn`  in  7  {insn30, insn29, insn27, insn26, insn14, insn12, insn3}.
- `sh_din_valid`  out  1  to shifter `din_valid`.
- `sh_din_ready`  in  1  from shifter `din_ready`.
- `sh_din_rs1`, `sh_din_rs2`, `sh_din_rs3`  out  XLEN  to shifter operands.
- `sh_din_insn`  out  7  same packing as `reqN_insn`; unpacked at top level.
- `sh_dout_valid`  in  1  from shifter.
- `sh_dout_ready`  out  1  to shifter.
- `sh_dout_rd`  in  XLEN  shifter result.
- `rsp0_valid` / `rsp1_valid`  out  1  result available for port 0/1.
- `rsp0_ready` / `rsp1_ready`  in  1  requester consumes result.
- `rsp0_rd` / `rsp1_rd`  out  XLEN  result; both are wired to `sh_dout_rd`.
- `busy`  out  1  registered; high when outstanding count is nonzero.

## Operation
- State:
  - issue register: valid bit, operands, insn.
  - round-robin pointer `prio`, 1 bit.
  - tag FIFO: DEPTH entries of 1 bit.
  - outstanding count, 0..DEPTH.
- `load` = (!issue_valid || (sh_din_valid && sh_din_ready)) && (count != DEPTH). `count` is the registered value.
- Grant:
  - Only one port valid: that port wins.
  - Both valid: port `prio` wins.
  - `reqN_ready` = load && grant==N. It is independent of `reqM_valid` for M != N only through the grant.
- On an accepted request:
  - issue register loads the operands;
  - the tag (port number) is pushed to the FIFO;
  - `prio` <= ~N.
- `prio` is unchanged on cycles with no grant.
- Issue register clears when the shifter accepts and no new request is loaded.
- Response steering, with head = FIFO head tag:
  - `sh_dout_ready` = !empty && rsp_head_ready.
  - `rspN_valid` = sh_dout_valid && !empty && head==N.
- FIFO pops on `sh_dout_valid && sh_dout_ready`.
- Count update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full: no push while count==DEPTH, even if a pop occurs in the same cycle. This is a deliberate one-cycle bubble so the full check never depends on the combinational pop path.
- `sh_dout_valid` while FIFO empty is a shifter protocol violation. It is ignored (`sh_dout_ready`=0, no rsp valid) and flagged by a simulation-only `$error`.
- Results return in issue order. A stalled head response blocks results for the other port; this is intended.

## Timing
- Reset values:
  - outputs: `sh_din_valid`=0, `busy`=0, `rsp0_valid`=`rsp1_valid`=0, `sh_dout_ready`=0, `req0_ready`=`req1_ready`=0;
  - state: `prio`=0, count=0, FIFO pointers=0.
- Reset mid-operation discards the issue register and all tags. The shifter shares `reset`, so no stale result returns.
- Issue latency: a request accepted at edge N presents `sh_din_valid`=1 with its operands from N+1.
- Holding: operands stay stable while `sh_din_valid && !sh_din_ready`.
- Throughput: one issue per cycle while the shifter is ready and count < DEPTH.
- Response path: combinational, zero added cycles. `rspN_rd` equals `sh_dout_rd` in the same cycle.
- `busy` reflects count after each edge.

## Test plan
- Single port: 4 back-to-back requests on port 0 (shifter always ready, fixed 1-cycle latency), rs1=0x0000_00F0, rs2=4, srl encoding.
  - `req0_ready`=1 every cycle;
  - rsp0 delivers 4 results of 0x0000_000F in order;
  - `rsp1_valid` never rises.
- Fairness: both ports valid continuously for 8 cycles from reset.
  - Grants alternate 0,1,0,1,…;
  - each response port receives exactly 4 results in its own issue order.
- Full: hold `sh_dout_ready`-side backpressure via `rsp0_ready`=0 with DEPTH=4.
  - After 4 accepts, `req0_ready`=`req1_ready`=0 and count=4.
  - Raising `rsp0_ready` pops one result.
  - The next accept occurs exactly one cycle after that pop.
- Head-of-line: issue port 1 then port 0, with `rsp1_ready`=0 for 5 cycles.
  - `rsp0_valid` stays 0 until rsp1 completes;
  - port-0 result follows on the next cycle.
- Stall: `sh_din_ready`=0 for 3 cycles with the issue register loaded.
  - `sh_din_*` remain stable;
  - `req*_ready`=0;
  - issue resumes on the cycle `sh_din_ready` returns.
- Reset: assert `reset` for 1 cycle with 3 outstanding.
  - Next cycle: `busy`=0, `sh_din_valid`=0, `rsp*_valid`=0;
  - first post-reset grant goes to port 0 when both are valid.

Source files
------------

// File: rtl/rvb_shifter_arbiter.sv
// Shares one rvb_shifter between two requesters: round-robin grant into a registered
// issue stage, an in-order tag FIFO, and combinational steering of results back to the owner.
module rvb_shifter_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic [XLEN-1:0] req0_rs3,
    input  logic [6:0]      req0_insn,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    input  logic [XLEN-1:0] req1_rs3,
    input  logic [6:0]      req1_insn,

    output logic            sh_din_valid,
    input  logic            sh_din_ready,
    output logic [XLEN-1:0] sh_din_rs1,
    output logic [XLEN-1:0] sh_din_rs2,
    output logic [XLEN-1:0] sh_din_rs3,
    output logic [6:0]      sh_din_insn,

    input  logic            sh_dout_valid,
    output logic            sh_dout_ready,
    input  logic [XLEN-1:0] sh_dout_rd,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_rd,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_rd,

    output logic            busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic             issue_valid_q, issue_valid_d;
    logic [XLEN-1:0]  issue_rs1_q, issue_rs1_d;
    logic [XLEN-1:0]  issue_rs2_q, issue_rs2_d;
    logic [XLEN-1:0]  issue_rs3_q, issue_rs3_d;
    logic [6:0]       issue_insn_q, issue_insn_d;
    logic             prio_q, prio_d;
    logic [DEPTH-1:0] tag_q, tag_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;

    logic fifo_empty;
    logic head;
    logic load;
    logic any_req;
    logic grant;
    logic push;
    logic pop;

    // The full check uses only the registered count, so a pop never frees a slot in the same cycle.
    always_comb begin
        fifo_empty = (count_q == '0);
        head       = tag_q[rd_ptr_q];
        load       = (!issue_valid_q || (issue_valid_q && sh_din_ready)) && (count_q != FULL_COUNT);
        any_req    = req0_valid || req1_valid;
        grant      = (req0_valid && req1_valid) ? prio_q : req1_valid;
        push       = !reset && load && any_req;

        req0_ready    = push && !grant;
        req1_ready    = push && grant;

        sh_din_valid  = issue_valid_q;
        sh_din_rs1    = issue_rs1_q;
        sh_din_rs2    = issue_rs2_q;
        sh_din_rs3    = issue_rs3_q;
        sh_din_insn   = issue_insn_q;

        sh_dout_ready = !fifo_empty && (head ? rsp1_ready : rsp0_ready);
        rsp0_valid    = sh_dout_valid && !fifo_empty && !head;
        rsp1_valid    = sh_dout_valid && !fifo_empty && head;
        rsp0_rd       = sh_dout_rd;
        rsp1_rd       = sh_dout_rd;
        pop           = sh_dout_valid && sh_dout_ready;

        busy          = busy_q;
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_rs1_d   = issue_rs1_q;
        issue_rs2_d   = issue_rs2_q;
        issue_rs3_d   = issue_rs3_q;
        issue_insn_d  = issue_insn_q;
        prio_d        = prio_q;
        tag_d         = tag_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (push) begin
            issue_valid_d   = 1'b1;
            issue_rs1_d     = grant ? req1_rs1 : req0_rs1;
            issue_rs2_d     = grant ? req1_rs2 : req0_rs2;
            issue_rs3_d     = grant ? req1_rs3 : req0_rs3;
            issue_insn_d    = grant ? req1_insn : req0_insn;
            prio_d          = !grant;
            tag_d[wr_ptr_q] = grant;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else if (issue_valid_q && sh_din_ready) begin
            issue_valid_d = 1'b0;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        busy_d = (count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            issue_valid_q <= 1'b0;
            issue_rs1_q   <= '0;
            issue_rs2_q   <= '0;
            issue_rs3_q   <= '0;
            issue_insn_q  <= '0;
            prio_q        <= 1'b0;
            tag_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            busy_q        <= 1'b0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_rs1_q   <= issue_rs1_d;
            issue_rs2_q   <= issue_rs2_d;
            issue_rs3_q   <= issue_rs3_d;
            issue_insn_q  <= issue_insn_d;
            prio_q        <= prio_d;
            tag_q         <= tag_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            busy_q        <= busy_d;
        end
    end

`ifndef SYNTHESIS
    // A result with no outstanding tag means the shifter broke its protocol; it is dropped.
    always @(posedge clock) begin
        if (!reset && sh_dout_valid && fifo_empty)
            $error("rvb_shifter_arbiter: sh_dout_valid with no outstanding operation");
    end
`endif

endmodule

// File: tb/tb_rvb_shifter_arbiter.sv
// Self-checking bench for rvb_shifter_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a queue-based reference model with an emulated srl shifter.
module tb_rvb_shifter_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [6:0] SRL = 7'b0000110;

    logic            clock = 1'b0;
    logic            reset;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [XLEN-1:0] req0_rs1, req0_rs2, req0_rs3, req1_rs1, req1_rs2, req1_rs3;
    logic [6:0]      req0_insn, req1_insn;
    logic            sh_din_valid, sh_din_ready;
    logic [XLEN-1:0] sh_din_rs1, sh_din_rs2, sh_din_rs3;
    logic [6:0]      sh_din_insn;
    logic            sh_dout_valid, sh_dout_ready;
    logic [XLEN-1:0] sh_dout_rd;
    logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [XLEN-1:0] rsp0_rd, rsp1_rd;
    logic            busy;

    always #5 clock = ~clock;

    rvb_shifter_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_rs3(req0_rs3), .req0_insn(req0_insn),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_rs3(req1_rs3), .req1_insn(req1_insn),
        .sh_din_valid(sh_din_valid), .sh_din_ready(sh_din_ready),
        .sh_din_rs1(sh_din_rs1), .sh_din_rs2(sh_din_rs2), .sh_din_rs3(sh_din_rs3),
        .sh_din_insn(sh_din_insn),
        .sh_dout_valid(sh_dout_valid), .sh_dout_ready(sh_dout_ready), .sh_dout_rd(sh_dout_rd),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rd(rsp0_rd),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rd(rsp1_rd),
        .busy(busy)
    );

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] rs3;
        logic [6:0]      insn;
    } op_t;

    typedef struct {
        bit rst_before;
        bit r0v, r1v, dinr, rsp0r, rsp1r;
        bit e_r0rdy, e_r1rdy, e_dinv, e_rsp0v, e_rsp1v, e_busy;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: accepted-but-unreturned ops as an ordered list of owner ports,
    // the op sitting in the issue slot, and per-port queues of expected results.
    bit              m_prio;
    bit              m_iss_v;
    op_t             m_iss;
    bit              m_tags[$];
    logic [XLEN-1:0] m_exp0[$];
    logic [XLEN-1:0] m_exp1[$];
    // Emulated shifter: results in flight, in acceptance order.
    logic [XLEN-1:0] shq[$];

    logic            a_r0rdy, a_r1rdy, a_dinv, a_rsp0v, a_rsp1v, a_dordy, a_busy;
    logic [XLEN-1:0] a_dinrs1, a_rsp0rd;

    vec_t vecs[$];

    function automatic logic [XLEN-1:0] srlRef(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return a >> b[4:0];
    endfunction

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic doReset(input int n);
        reset         = 1'b1;
        req0_valid    = 1'b0;
        req1_valid    = 1'b0;
        sh_din_ready  = 1'b0;
        rsp0_ready    = 1'b0;
        rsp1_ready    = 1'b0;
        sh_dout_valid = 1'b0;
        sh_dout_rd    = '0;
        repeat (n) @(posedge clock);
        @(negedge clock);
        reset   = 1'b0;
        m_prio  = 1'b0;
        m_iss_v = 1'b0;
        m_tags.delete();
        m_exp0.delete();
        m_exp1.delete();
        shq.delete();
    endtask

    // One clock cycle: drive inputs at the falling edge, check against the model, then advance it.
    task automatic applyStimulus(input bit r0v, input bit r1v, input bit dinr, input bit rsp0r, input bit rsp1r);
        bit              dv, empty, head, load, gnt, p_r0, p_r1, p_drdy, hb;
        op_t             dop, nop;
        logic [XLEN-1:0] exp, junk;
        req0_valid   = r0v;
        req1_valid   = r1v;
        sh_din_ready = dinr;
        rsp0_ready   = rsp0r;
        rsp1_ready   = rsp1r;
        dv            = (shq.size() != 0);
        sh_dout_valid = dv;
        sh_dout_rd    = dv ? shq[0] : '0;
        #1;
        empty  = (m_tags.size() == 0);
        head   = empty ? 1'b0 : m_tags[0];
        load   = (!m_iss_v || dinr) && (m_tags.size() != DEPTH);
        gnt    = (r0v && r1v) ? m_prio : r1v;
        p_r0   = load && r0v && !gnt;
        p_r1   = load && r1v && gnt;
        p_drdy = !empty && (head ? rsp1r : rsp0r);

        a_r0rdy = req0_ready;   a_r1rdy = req1_ready;   a_dinv = sh_din_valid;
        a_rsp0v = rsp0_valid;   a_rsp1v = rsp1_valid;   a_dordy = sh_dout_ready;
        a_busy  = busy;         a_dinrs1 = sh_din_rs1;  a_rsp0rd = rsp0_rd;

        checkOutput("req0_ready", XLEN'(req0_ready), XLEN'(p_r0));
        checkOutput("req1_ready", XLEN'(req1_ready), XLEN'(p_r1));
        checkOutput("sh_din_valid", XLEN'(sh_din_valid), XLEN'(m_iss_v));
        checkOutput("busy", XLEN'(busy), XLEN'(!empty));
        checkOutput("sh_dout_ready", XLEN'(sh_dout_ready), XLEN'(p_drdy));
        checkOutput("rsp0_valid", XLEN'(rsp0_valid), XLEN'(dv && !empty && !head));
        checkOutput("rsp1_valid", XLEN'(rsp1_valid), XLEN'(dv && !empty && head));
        if (m_iss_v) begin
            checkOutput("sh_din_rs1", sh_din_rs1, m_iss.rs1);
            checkOutput("sh_din_rs2", sh_din_rs2, m_iss.rs2);
            checkOutput("sh_din_rs3", sh_din_rs3, m_iss.rs3);
            checkOutput("sh_din_insn", XLEN'(sh_din_insn), XLEN'(m_iss.insn));
        end
        if (dv && p_drdy) begin
            if (head) begin
                exp = (m_exp1.size() != 0) ? m_exp1.pop_front() : 'x;
                checkOutput("rsp1_rd", rsp1_rd, exp);
            end else begin
                exp = (m_exp0.size() != 0) ? m_exp0.pop_front() : 'x;
                checkOutput("rsp0_rd", rsp0_rd, exp);
            end
        end
        dop = '{sh_din_rs1, sh_din_rs2, sh_din_rs3, sh_din_insn};

        @(posedge clock);
        if (dv && p_drdy) begin
            junk = shq.pop_front();
            hb   = m_tags.pop_front();
        end
        if (m_iss_v && dinr)
            shq.push_back(srlRef(dop.rs1, dop.rs2));
        if (p_r0 || p_r1) begin
            nop = gnt ? '{req1_rs1, req1_rs2, req1_rs3, req1_insn}
                      : '{req0_rs1, req0_rs2, req0_rs3, req0_insn};
            m_tags.push_back(gnt);
            if (gnt) m_exp1.push_back(srlRef(nop.rs1, nop.rs2));
            else     m_exp0.push_back(srlRef(nop.rs1, nop.rs2));
            m_iss   = nop;
            m_iss_v = 1'b1;
            m_prio  = !gnt;
        end else if (m_iss_v && dinr) begin
            m_iss_v = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic addVec(input bit rb, input bit r0v, input bit r1v, input bit dinr, input bit rsp0r,
                          input bit rsp1r, input bit e0, input bit e1, input bit ed, input bit ev0,
                          input bit ev1, input bit eb);
        vec_t v;
        v = '{rb, r0v, r1v, dinr, rsp0r, rsp1r, e0, e1, ed, ev0, ev1, eb};
        vecs.push_back(v);
    endtask

    task automatic drain(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        req0_rs1 = '0; req0_rs2 = '0; req0_rs3 = '0; req0_insn = SRL;
        req1_rs1 = '0; req1_rs2 = '0; req1_rs3 = '0; req1_insn = SRL;

        // Single port: four back-to-back srl requests on port 0, then drain.
        //     rb r0 r1 dr p0 p1 | r0rdy r1rdy dinv rsp0v rsp1v busy
        addVec(1, 1, 0, 1, 1, 1,   1, 0, 0, 0, 0, 0);
        addVec(0, 1, 0, 1, 1, 1,   1, 0, 1, 0, 0, 1);
        addVec(0, 1, 0, 1, 1, 1,   1, 0, 1, 1, 0, 1);
        addVec(0, 1, 0, 1, 1, 1,   1, 0, 1, 1, 0, 1);
        addVec(0, 0, 0, 1, 1, 1,   0, 0, 1, 1, 0, 1);
        addVec(0, 0, 0, 1, 1, 1,   0, 0, 0, 1, 0, 1);
        addVec(0, 0, 0, 1, 1, 1,   0, 0, 0, 0, 0, 0);
        // Fairness: both ports valid for 8 cycles from reset, grants alternate 0,1,0,1...
        addVec(1, 1, 1, 1, 1, 1,   1, 0, 0, 0, 0, 0);
        addVec(0, 1, 1, 1, 1, 1,   0, 1, 1, 0, 0, 1);
        addVec(0, 1, 1, 1, 1, 1,   1, 0, 1, 1, 0, 1);
        addVec(0, 1, 1, 1, 1, 1,   0, 1, 1, 0, 1, 1);
        addVec(0, 1, 1, 1, 1, 1,   1, 0, 1, 1, 0, 1);
        addVec(0, 1, 1, 1, 1, 1,   0, 1, 1, 0, 1, 1);
        addVec(0, 1, 1, 1, 1, 1,   1, 0, 1, 1, 0, 1);
        addVec(0, 1, 1, 1, 1, 1,   0, 1, 1, 0, 1, 1);
        addVec(0, 0, 0, 1, 1, 1,   0, 0, 1, 1, 0, 1);
        addVec(0, 0, 0, 1, 1, 1,   0, 0, 0, 0, 1, 1);
        addVec(0, 0, 0, 1, 1, 1,   0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) doReset(2);
            req0_rs1 = 32'h0000_00F0;      req0_rs2 = 32'd4; req0_rs3 = XLEN'(i);  req0_insn = SRL;
            req1_rs1 = 32'hABCD_0000 + XLEN'(i); req1_rs2 = '0; req1_rs3 = ~XLEN'(i); req1_insn = 7'b1000110;
            applyStimulus(vecs[i].r0v, vecs[i].r1v, vecs[i].dinr, vecs[i].rsp0r, vecs[i].rsp1r);
            checkOutput($sformatf("vec%0d req0_ready", i), XLEN'(a_r0rdy), XLEN'(vecs[i].e_r0rdy));
            checkOutput($sformatf("vec%0d req1_ready", i), XLEN'(a_r1rdy), XLEN'(vecs[i].e_r1rdy));
            checkOutput($sformatf("vec%0d sh_din_valid", i), XLEN'(a_dinv), XLEN'(vecs[i].e_dinv));
            checkOutput($sformatf("vec%0d rsp0_valid", i), XLEN'(a_rsp0v), XLEN'(vecs[i].e_rsp0v));
            checkOutput($sformatf("vec%0d rsp1_valid", i), XLEN'(a_rsp1v), XLEN'(vecs[i].e_rsp1v));
            checkOutput($sformatf("vec%0d busy", i), XLEN'(a_busy), XLEN'(vecs[i].e_busy));
            if (i >= 2 && i <= 5)
                checkOutput($sformatf("vec%0d srl result", i), a_rsp0rd, 32'h0000_000F);
        end

        // Full: four accepts with port 0 responses blocked, then a one-cycle bubble after the pop.
        doReset(2);
        req0_rs1 = 32'h8000_0000; req0_rs2 = 32'd31; req0_rs3 = '0; req0_insn = SRL;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            checkOutput($sformatf("full accept%0d", i), XLEN'(a_r0rdy), 1);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            checkOutput($sformatf("full hold%0d req0_ready", i), XLEN'(a_r0rdy), 0);
            checkOutput($sformatf("full hold%0d req1_ready", i), XLEN'(a_r1rdy), 0);
            checkOutput($sformatf("full hold%0d busy", i), XLEN'(a_busy), 1);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("full pop rsp0_valid", XLEN'(a_rsp0v), 1);
        checkOutput("full pop sh_dout_ready", XLEN'(a_dordy), 1);
        checkOutput("full pop bubble req0_ready", XLEN'(a_r0rdy), 0);
        checkOutput("full pop bubble req1_ready", XLEN'(a_r1rdy), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("full reaccept req1_ready", XLEN'(a_r1rdy), 1);
        drain(12);

        // Stall: shifter not ready for three cycles holds the issued operands.
        doReset(2);
        req0_rs1 = 32'h1234_5678; req0_rs2 = 32'd8; req0_rs3 = 32'h55; req0_insn = SRL;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("stall first accept", XLEN'(a_r0rdy), 1);
        req0_rs1 = 32'hDEAD_BEEF; req0_rs2 = 32'd1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("stall%0d req0_ready", i), XLEN'(a_r0rdy), 0);
            checkOutput($sformatf("stall%0d sh_din_valid", i), XLEN'(a_dinv), 1);
            checkOutput($sformatf("stall%0d sh_din_rs1", i), a_dinrs1, 32'h1234_5678);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("stall resume req0_ready", XLEN'(a_r0rdy), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("stall next sh_din_rs1", a_dinrs1, 32'hDEAD_BEEF);
        drain(8);

        // Head-of-line: port 1 result stalled blocks the younger port 0 result.
        doReset(2);
        req1_rs1 = 32'h0000_1111; req1_rs2 = '0;
        req0_rs1 = 32'h0000_2222; req0_rs2 = '0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("hol port1 accept", XLEN'(a_r1rdy), 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("hol port0 accept", XLEN'(a_r0rdy), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("hol blocked%0d rsp0_valid", i), XLEN'(a_rsp0v), 0);
            checkOutput($sformatf("hol blocked%0d rsp1_valid", i), XLEN'(a_rsp1v), 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("hol release rsp0_valid", XLEN'(a_rsp0v), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("hol follow rsp0_valid", XLEN'(a_rsp0v), 1);
        checkOutput("hol follow rsp0_rd", a_rsp0rd, 32'h0000_2222);
        drain(6);

        // Reset with three outstanding operations and priority pointing at port 1.
        doReset(2);
        req0_rs1 = 32'h0000_0F0F; req0_rs2 = 32'd2;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        doReset(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("post-reset busy", XLEN'(a_busy), 0);
        checkOutput("post-reset sh_din_valid", XLEN'(a_dinv), 0);
        checkOutput("post-reset rsp0_valid", XLEN'(a_rsp0v), 0);
        checkOutput("post-reset rsp1_valid", XLEN'(a_rsp1v), 0);
        checkOutput("post-reset grant port0", XLEN'(a_r0rdy), 1);
        checkOutput("post-reset no grant port1", XLEN'(a_r1rdy), 0);
        drain(8);

        // Randomized traffic with occasional mid-run resets.
        doReset(2);
        for (int c = 0; c < 4000; c++) begin
            req0_rs1 = $urandom(); req0_rs2 = $urandom(); req0_rs3 = $urandom(); req0_insn = 7'($urandom());
            req1_rs1 = $urandom(); req1_rs2 = $urandom(); req1_rs3 = $urandom(); req1_insn = 7'($urandom());
            if ($urandom_range(0, 599) == 0) doReset(1);
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 8,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
        end
        drain(20);
        checkOutput("final busy", XLEN'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
